// File: rtl/sram_controller_pkg.sv
// Shared widths, address base and FSM encoding for the 32-bit-over-16-bit SRAM controller.
package sram_controller_pkg;

  localparam int unsigned REGISTER_LEN  = 32;
  localparam int unsigned SRAM_DATA_LEN = 16;
  localparam int unsigned SRAM_ADDR_LEN = 18;
  localparam int unsigned WORD_LEN      = SRAM_ADDR_LEN - 1;

  localparam logic [REGISTER_LEN-1:0] DATA_MEM_BASE = 32'd1024;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh,
    StDone
  } state_e;

  // Word index inside the SRAM; out-of-range addresses simply wrap.
  function automatic logic [WORD_LEN-1:0] word_of(input logic [REGISTER_LEN-1:0] addr);
    return WORD_LEN'((addr - DATA_MEM_BASE) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline memory-stage request bus plus the SRAM pin bundle.
interface sram_controller_if;
  import sram_controller_pkg::*;

  logic                     rd_en;
  logic                     wr_en;
  logic [REGISTER_LEN-1:0]  address;
  logic [REGISTER_LEN-1:0]  write_data;
  logic [REGISTER_LEN-1:0]  read_data;
  logic                     ready;
  logic [SRAM_ADDR_LEN-1:0] sram_addr;
  logic [SRAM_DATA_LEN-1:0] sram_dq_out;
  logic                     sram_dq_oe;
  logic [SRAM_DATA_LEN-1:0] sram_dq_in;
  logic                     sram_we_n;
  logic                     sram_oe_n;

  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );

  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );

endinterface

// File: rtl/sram_controller_wait_counter.sv
// Phase-length counter: done once Limit extra cycles have elapsed; saturates there.
module wait_counter #(
  parameter int unsigned Limit = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  logic [2:0] count_q;

  assign done = (count_q == 3'(Limit));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= 3'd0;
    end else if (en && !done) begin
      count_q <= count_q + 3'd1;
    end
  end

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit SRAM accesses, stalling the pipeline meanwhile.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   bus
);

  state_e                  state_q;
  logic                    op_write_q;
  logic [REGISTER_LEN-1:0] addr_q;
  logic [REGISTER_LEN-1:0] wdata_q;
  logic [REGISTER_LEN-1:0] rdata_q;

  logic request;
  logic in_access;
  logic cnt_clr;
  logic cnt_done;

  assign request   = bus.rd_en | bus.wr_en;
  assign in_access = (state_q == StLow) || (state_q == StHigh);
  // Clearing on the final cycle of a phase gives the next phase a fresh count.
  assign cnt_clr   = !in_access || cnt_done;

  wait_counter #(
    .Limit (WAIT_CYCLES)
  ) u_wait_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (in_access),
    .done (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (request) begin
            op_write_q <= bus.wr_en;
            addr_q     <= bus.address;
            wdata_q    <= bus.write_data;
            state_q    <= StLow;
          end
        end
        StLow: begin
          if (cnt_done) begin
            if (!op_write_q) rdata_q[15:0] <= bus.sram_dq_in;
            state_q <= StHigh;
          end
        end
        StHigh: begin
          if (cnt_done) begin
            if (!op_write_q) rdata_q[31:16] <= bus.sram_dq_in;
            state_q <= StDone;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Reset forces the idle pin state immediately so an aborted store cannot strobe again.
  always_comb begin
    bus.sram_addr   = '0;
    bus.sram_dq_out = '0;
    bus.sram_dq_oe  = 1'b0;
    bus.sram_we_n   = 1'b1;
    bus.sram_oe_n   = 1'b1;
    if (!rst && in_access) begin
      bus.sram_addr = {word_of(addr_q), state_q == StHigh};
      if (op_write_q) begin
        bus.sram_dq_oe  = 1'b1;
        bus.sram_we_n   = 1'b0;
        bus.sram_dq_out = (state_q == StHigh) ? wdata_q[31:16] : wdata_q[15:0];
      end else begin
        bus.sram_oe_n = 1'b0;
      end
    end
  end

  always_comb begin
    bus.ready = 1'b0;
    if (rst || state_q == StIdle) begin
      bus.ready = !request;
    end else if (state_q == StDone) begin
      bus.ready = 1'b1;
    end
  end

  assign bus.read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed plus random bench for sram_controller at WAIT_CYCLES of 0, 1 and 7 over one SRAM model.
module tb_sram_controller;
  import sram_controller_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_controller_if b0 ();
  sram_controller_if b1 ();
  sram_controller_if b7 ();

  sram_controller #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  sram_controller #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  sram_controller #(.WAIT_CYCLES(7)) dut7 (.clk(clk), .rst(rst), .bus(b7));

  logic        rd, wr;
  logic [31:0] addr, wdata;
  logic [1:0]  sel;

  always_comb begin
    b0.rd_en = rd && (sel == 2'd0);
    b0.wr_en = wr && (sel == 2'd0);
    b1.rd_en = rd && (sel == 2'd1);
    b1.wr_en = wr && (sel == 2'd1);
    b7.rd_en = rd && (sel == 2'd2);
    b7.wr_en = wr && (sel == 2'd2);
    b0.address = addr;
    b1.address = addr;
    b7.address = addr;
    b0.write_data = wdata;
    b1.write_data = wdata;
    b7.write_data = wdata;
  end

  logic        o_ready, o_oe, o_we_n, o_oe_n;
  logic [17:0] o_addr;
  logic [15:0] o_dq;
  logic [31:0] o_rdata;

  always_comb begin
    case (sel)
      2'd0: begin
        o_ready = b0.ready; o_addr = b0.sram_addr; o_dq = b0.sram_dq_out; o_oe = b0.sram_dq_oe;
        o_we_n = b0.sram_we_n; o_oe_n = b0.sram_oe_n; o_rdata = b0.read_data;
      end
      2'd2: begin
        o_ready = b7.ready; o_addr = b7.sram_addr; o_dq = b7.sram_dq_out; o_oe = b7.sram_dq_oe;
        o_we_n = b7.sram_we_n; o_oe_n = b7.sram_oe_n; o_rdata = b7.read_data;
      end
      default: begin
        o_ready = b1.ready; o_addr = b1.sram_addr; o_dq = b1.sram_dq_out; o_oe = b1.sram_dq_oe;
        o_we_n = b1.sram_we_n; o_oe_n = b1.sram_oe_n; o_rdata = b1.read_data;
      end
    endcase
  end

  // SRAM model: 16-bit cells, written on any clock edge where the active controller strobes.
  bit [15:0] mem [262144];
  always @(posedge clk) if (o_we_n === 1'b0) mem[o_addr] <= o_dq;
  assign b0.sram_dq_in = mem[b0.sram_addr];
  assign b1.sram_dq_in = mem[b1.sram_addr];
  assign b7.sram_dq_in = mem[b7.sram_addr];

  // Reference: 32-bit word store plus the last loaded value per controller.
  bit   [31:0] ref_mem [131072];
  logic [31:0] rd_model [3];

  int total = 0;
  int bad   = 0;

  function automatic logic [16:0] tb_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return 17'(off / 4 % 131072);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic access(input int s, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d);
    int          wc   = (s == 0) ? 0 : (s == 1) ? 1 : 7;
    int          last = 2 * wc + 3;
    logic [16:0] wd   = tb_word(a);
    bit          lo, hi;
    logic        e_oe, e_we_n, e_oe_n;
    logic [17:0] e_addr;
    logic [15:0] e_dq;
    @(posedge clk);
    #1;
    sel = 2'(s); rd = r; wr = w; addr = a; wdata = d;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      lo = (c >= 1) && (c <= wc + 1);
      hi = (c >= wc + 2) && (c <= last - 1);
      e_addr = 18'd0; e_dq = 16'd0; e_oe = 1'b0; e_we_n = 1'b1; e_oe_n = 1'b1;
      if (lo || hi) begin
        e_addr = {wd, hi};
        e_oe   = w;
        e_we_n = !w;
        e_oe_n = w;
        e_dq   = hi ? d[31:16] : d[15:0];
      end
      check("ready", {63'd0, o_ready}, {63'd0, c == last});
      check("pins", {o_addr, o_oe, o_we_n, o_oe_n}, {e_addr, e_oe, e_we_n, e_oe_n});
      if (w || !(lo || hi)) check("dq_out", o_dq, e_dq);
      if (c == 0) check("rdata_hold", o_rdata, rd_model[s]);
    end
    if (w) ref_mem[wd] = d;
    else   rd_model[s] = ref_mem[wd];
    check("rdata", o_rdata, rd_model[s]);
    rd = 1'b0;
    wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] pool [6];
  int          s, op;

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; sel = 2'd1; addr = '0; wdata = '0;
    for (int i = 0; i < 3; i++) rd_model[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {63'd0, o_ready}, 64'd1);
    check("rst_pins", {o_addr, o_dq, o_oe, o_we_n, o_oe_n}, {18'd0, 16'd0, 3'b011});
    check("rst_rdata", o_rdata, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    access(1, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    access(1, 1'b0, 1'b1, 32'd1028, 32'h12345678);
    access(1, 1'b1, 1'b0, 32'd1028, 32'h0);
    access(1, 1'b1, 1'b1, 32'd1032, 32'hCAFEF00D);

    // Abort a store during its second HIGH cycle.
    @(posedge clk);
    #1 sel = 2'd1; wr = 1'b1; addr = 32'd1040; wdata = 32'hA5A55A5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_high", {o_addr, o_dq, o_we_n}, {17'd4, 1'b1, 16'hA5A5, 1'b0});
    @(posedge clk);
    #1 rst = 1'b1; wr = 1'b0;
    @(negedge clk);
    check("abort_rst_pins", {o_ready, o_we_n, o_oe}, {1'b1, 1'b1, 1'b0});
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) rd_model[i] = '0;
    @(negedge clk);
    check("abort_idle", {o_ready, o_we_n, o_oe, o_addr}, {1'b1, 1'b1, 1'b0, 18'd0});
    check("abort_rdata", o_rdata, 64'd0);
    access(1, 1'b1, 1'b0, 32'd1028, 32'h0);

    // Request held across two accesses, switched right after DONE.
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1 sel = 2'd1; rd = 1'b1; wr = 1'b0; addr = (c < 6) ? 32'd1028 : 32'd1024;
      @(negedge clk);
      check("b2b_ready", {63'd0, o_ready}, {63'd0, (c == 5) || (c == 11)});
      if (c == 5)  check("b2b_rdata_a", o_rdata, ref_mem[1]);
      if (c == 11) check("b2b_rdata_b", o_rdata, ref_mem[0]);
    end
    rd = 1'b0;
    rd_model[1] = ref_mem[0];

    access(0, 1'b1, 1'b0, 32'd1024, 32'h0);
    access(2, 1'b1, 1'b0, 32'd1024, 32'h0);

    for (int i = 0; i < 6; i++) begin
      do pool[i] = $urandom; while (tb_word(pool[i]) == 17'd4);
    end
    for (int n = 0; n < 40; n++) begin
      s  = $urandom_range(0, 2);
      op = $urandom_range(0, 2);
      access(s, op != 1, op != 0, pool[$urandom_range(0, 5)], $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
